// File: rtl/csr_access_issuer.sv
// Initiator side of the CSR regfile access interface.
// Accepts one CSR instruction from issue and parks it until commit reports the
// same trans_id at its head. It then issues one single-cycle access to the regfile,
// captures the read data and any exception, and returns a writeback response.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              squashes an entry that has not been committed yet
//   issue_*              instruction hand-off from the issue stage
//   commit_*             commit-head id match, with a combinational ack
//   csr_*_o / csr_*_i    single-cycle access strobe to csr_regfile and its result
//   rsp_*                writeback response (valid/ready)
//   hold_cycles_o        number of cycles the last committed entry waited for commit
module csr_access_issuer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [1:0]               issue_op_i,
  input  logic                     issue_no_write_i,
  input  logic [11:0]              issue_addr_i,
  input  logic [XLEN-1:0]          issue_wdata_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic                     commit_valid_i,
  input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
  output logic                     commit_ack_o,
  output logic                     csr_req_o,
  output logic [1:0]               csr_op_o,
  output logic [11:0]              csr_addr_o,
  output logic [XLEN-1:0]          csr_wdata_o,
  input  logic [XLEN-1:0]          csr_rdata_i,
  input  logic                     csr_ex_valid_i,
  input  logic [XLEN-1:0]          csr_ex_cause_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [TRANS_ID_BITS-1:0] rsp_trans_id_o,
  output logic [XLEN-1:0]          rsp_rdata_o,
  output logic                     rsp_ex_valid_o,
  output logic [XLEN-1:0]          rsp_ex_cause_o,
  output logic [CNT_WIDTH-1:0]     hold_cycles_o
);

  localparam logic [1:0] OpRead = 2'b00;

  typedef enum logic [1:0] {StIdle, StHold, StAccess, StResp} state_e;

  state_e                   r_state;
  logic                     r_issue_ready;
  logic                     r_csr_req;
  logic                     r_rsp_valid;
  logic [1:0]               r_op;
  logic [11:0]              r_addr;
  logic [XLEN-1:0]          r_wdata;
  logic [TRANS_ID_BITS-1:0] r_trans_id;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic [CNT_WIDTH-1:0]     r_hold_cycles;
  logic [XLEN-1:0]          r_rsp_rdata;
  logic                     r_rsp_ex_valid;
  logic [XLEN-1:0]          r_rsp_ex_cause;

  logic                     w_accept;
  logic                     w_commit_match;
  logic [1:0]               w_issue_op;

  // r_issue_ready is set only in IDLE, so it also gates acceptance.
  assign w_accept       = r_issue_ready & issue_valid_i;
  // Flush takes priority, so a squashed entry never acks a commit.
  assign w_commit_match = (r_state == StHold) & ~flush_i & commit_valid_i &
                          (commit_trans_id_i == r_trans_id);
  // SET/CLEAR with a zero operand only read the CSR; WRITE always writes.
  assign w_issue_op     = (issue_no_write_i && issue_op_i[1]) ? OpRead : issue_op_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= StIdle;
      r_issue_ready  <= 1'b0;
      r_csr_req      <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_op           <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_trans_id     <= '0;
      r_cnt          <= '0;
      r_hold_cycles  <= '0;
      r_rsp_rdata    <= '0;
      r_rsp_ex_valid <= 1'b0;
      r_rsp_ex_cause <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_issue_ready <= 1'b1;
          if (w_accept) begin
            r_op          <= w_issue_op;
            r_addr        <= issue_addr_i;
            r_wdata       <= issue_wdata_i;
            r_trans_id    <= issue_trans_id_i;
            r_cnt         <= '0;
            r_issue_ready <= 1'b0;
            r_state       <= StHold;
          end
        end
        StHold: begin
          if (r_cnt != {CNT_WIDTH{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (flush_i) begin
            r_issue_ready <= 1'b1;
            r_state       <= StIdle;
          end else if (w_commit_match) begin
            r_csr_req <= 1'b1;
            r_state   <= StAccess;
          end
        end
        StAccess: begin
          // Commit is irrevocable from here on, so flush_i is not consulted.
          r_csr_req      <= 1'b0;
          r_rsp_rdata    <= csr_rdata_i;
          r_rsp_ex_valid <= csr_ex_valid_i;
          r_rsp_ex_cause <= csr_ex_valid_i ? csr_ex_cause_i : '0;
          r_hold_cycles  <= r_cnt;
          r_rsp_valid    <= 1'b1;
          r_state        <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_rsp_valid   <= 1'b0;
            r_issue_ready <= 1'b1;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign issue_ready_o  = r_issue_ready;
  assign commit_ack_o   = w_commit_match;
  // Regfile bus is held at zero outside the access cycle.
  assign csr_req_o      = r_csr_req;
  assign csr_op_o       = r_csr_req ? r_op : '0;
  assign csr_addr_o     = r_csr_req ? r_addr : '0;
  assign csr_wdata_o    = r_csr_req ? r_wdata : '0;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_trans_id_o = r_trans_id;
  assign rsp_rdata_o    = r_rsp_rdata;
  assign rsp_ex_valid_o = r_rsp_ex_valid;
  assign rsp_ex_cause_o = r_rsp_ex_cause;
  assign hold_cycles_o  = r_hold_cycles;

endmodule

// File: tb/tb_csr_access_issuer.sv
module tb_csr_access_issuer;

  localparam int unsigned XLEN = 64;
  localparam int unsigned TIDW = 3;
  localparam int unsigned CNTW = 4;  // small width so saturation is reachable

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            issue_valid_i = 1'b0;
  logic            issue_ready_o;
  logic [1:0]      issue_op_i = '0;
  logic            issue_no_write_i = 1'b0;
  logic [11:0]     issue_addr_i = '0;
  logic [XLEN-1:0] issue_wdata_i = '0;
  logic [TIDW-1:0] issue_trans_id_i = '0;
  logic            commit_valid_i = 1'b0;
  logic [TIDW-1:0] commit_trans_id_i = '0;
  logic            commit_ack_o;
  logic            csr_req_o;
  logic [1:0]      csr_op_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic [XLEN-1:0] csr_rdata_i = '0;
  logic            csr_ex_valid_i = 1'b0;
  logic [XLEN-1:0] csr_ex_cause_i = '0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [TIDW-1:0] rsp_trans_id_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_ex_valid_o;
  logic [XLEN-1:0] rsp_ex_cause_o;
  logic [CNTW-1:0] hold_cycles_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_req = 0;
  int n_hs = 0;

  csr_access_issuer #(
    .XLEN(XLEN),
    .TRANS_ID_BITS(TIDW),
    .CNT_WIDTH(CNTW)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .issue_valid_i(issue_valid_i),
    .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i),
    .issue_no_write_i(issue_no_write_i),
    .issue_addr_i(issue_addr_i),
    .issue_wdata_i(issue_wdata_i),
    .issue_trans_id_i(issue_trans_id_i),
    .commit_valid_i(commit_valid_i),
    .commit_trans_id_i(commit_trans_id_i),
    .commit_ack_o(commit_ack_o),
    .csr_req_o(csr_req_o),
    .csr_op_o(csr_op_o),
    .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o),
    .csr_rdata_i(csr_rdata_i),
    .csr_ex_valid_i(csr_ex_valid_i),
    .csr_ex_cause_i(csr_ex_cause_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_trans_id_o(rsp_trans_id_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_ex_valid_o(rsp_ex_valid_o),
    .rsp_ex_cause_o(rsp_ex_cause_o),
    .hold_cycles_o(hold_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Count regfile strobes and response handshakes away from the active edge.
  always @(negedge clk_i) begin
    if (csr_req_o) n_req++;
    if (rsp_valid_o && rsp_ready_i) n_hs++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offers one instruction in IDLE; returns one cycle later in HOLD.
  task automatic do_issue(input logic [1:0] op, input logic nw, input logic [11:0] addr,
                          input logic [63:0] wd, input logic [TIDW-1:0] id);
    chk("issue_ready_idle", 64'(issue_ready_o), 64'd1);
    issue_valid_i    = 1'b1;
    issue_op_i       = op;
    issue_no_write_i = nw;
    issue_addr_i     = addr;
    issue_wdata_i    = wd;
    issue_trans_id_i = id;
    tick();
    issue_valid_i    = 1'b0;
    issue_no_write_i = 1'b0;
    chk("issue_ready_hold", 64'(issue_ready_o), 64'd0);
  endtask

  task automatic do_commit(input logic [TIDW-1:0] id, input logic exp_ack);
    commit_valid_i    = 1'b1;
    commit_trans_id_i = id;
    #1;
    chk("commit_ack", 64'(commit_ack_o), 64'(exp_ack));
    tick();
    commit_valid_i = 1'b0;
  endtask

  // In ACCESS: check the regfile strobe and its payload.
  task automatic chk_access(input logic [1:0] op, input logic [11:0] addr,
                            input logic [63:0] wd);
    chk("csr_req", 64'(csr_req_o), 64'd1);
    chk("csr_op", 64'(csr_op_o), 64'(op));
    chk("csr_addr", 64'(csr_addr_o), 64'(addr));
    chk("csr_wdata", 64'(csr_wdata_o), wd);
  endtask

  task automatic chk_resp(input logic [TIDW-1:0] id, input logic [63:0] rd, input logic exv,
                          input logic [63:0] cause, input logic [CNTW-1:0] hold);
    chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("rsp_trans_id", 64'(rsp_trans_id_o), 64'(id));
    chk("rsp_rdata", rsp_rdata_o, rd);
    chk("rsp_ex_valid", 64'(rsp_ex_valid_o), 64'(exv));
    chk("rsp_ex_cause", rsp_ex_cause_o, cause);
    chk("hold_cycles", 64'(hold_cycles_o), 64'(hold));
  endtask

  task automatic finish_resp();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("rsp_valid_done", 64'(rsp_valid_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_csr_req", 64'(csr_req_o), 64'd0);
    chk("rst_hold", 64'(hold_cycles_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // 1: WRITE 0x300/0x8, commit two cycles after accept
    csr_rdata_i = 64'h1800;
    do_issue(2'b01, 1'b0, 12'h300, 64'h8, 3'd1);
    tick();
    chk("no_ack_idle_commit", 64'(commit_ack_o), 64'd0);
    do_commit(3'd1, 1'b1);
    chk_access(2'b01, 12'h300, 64'h8);
    tick();
    chk_resp(3'd1, 64'h1800, 1'b0, 64'h0, 4'd2);
    finish_resp();
    chk("issue_ready_after_rsp", 64'(issue_ready_o), 64'd1);

    // 2: SET with zero operand becomes READ; immediate commit
    csr_rdata_i = 64'h0;
    do_issue(2'b10, 1'b1, 12'hF14, 64'h55, 3'd2);
    do_commit(3'd2, 1'b1);
    chk_access(2'b00, 12'hF14, 64'h55);
    tick();
    chk_resp(3'd2, 64'h0, 1'b0, 64'h0, 4'd1);
    finish_resp();

    // 3: WRITE with zero operand stays WRITE; mismatching id ignored
    csr_rdata_i = 64'h77;
    do_issue(2'b01, 1'b1, 12'h340, 64'h0, 3'd5);
    do_commit(3'd3, 1'b0);
    chk("no_req_on_mismatch", 64'(csr_req_o), 64'd0);
    do_commit(3'd5, 1'b1);
    chk_access(2'b01, 12'h340, 64'h0);
    tick();
    chk("csr_req_single", 64'(csr_req_o), 64'd0);
    chk("csr_op_idle_zero", 64'(csr_op_o), 64'd0);
    chk("csr_addr_idle_zero", 64'(csr_addr_o), 64'd0);
    chk_resp(3'd5, 64'h77, 1'b0, 64'h0, 4'd2);
    finish_resp();

    // 4: flush beats a matching commit in the same cycle
    do_issue(2'b01, 1'b0, 12'h305, 64'h1234, 3'd4);
    flush_i = 1'b1;
    do_commit(3'd4, 1'b0);
    flush_i = 1'b0;
    chk("flush_ready", 64'(issue_ready_o), 64'd1);
    chk("flush_no_req", 64'(csr_req_o), 64'd0);
    tick();
    chk("flush_no_rsp", 64'(rsp_valid_o), 64'd0);
    chk("flush_no_req2", 64'(csr_req_o), 64'd0);

    // 5: exception, stalled writeback, flush ignored in RESP
    csr_rdata_i    = 64'hABCD;
    csr_ex_valid_i = 1'b1;
    csr_ex_cause_i = 64'h2;
    do_issue(2'b11, 1'b0, 12'h301, 64'hF, 3'd6);
    tick();
    tick();
    do_commit(3'd6, 1'b1);
    chk_access(2'b11, 12'h301, 64'hF);
    tick();
    csr_rdata_i    = 64'hDEAD;
    csr_ex_valid_i = 1'b0;
    csr_ex_cause_i = 64'h9;
    flush_i        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_resp(3'd6, 64'hABCD, 1'b1, 64'h2, 4'd3);
      tick();
    end
    flush_i = 1'b0;
    chk_resp(3'd6, 64'hABCD, 1'b1, 64'h2, 4'd3);
    finish_resp();

    // 6: reset during ACCESS discards the entry
    csr_rdata_i = 64'h5;
    do_issue(2'b01, 1'b0, 12'h302, 64'h3, 3'd7);
    do_commit(3'd7, 1'b1);
    chk("pre_rst_req", 64'(csr_req_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_req_zero", 64'(csr_req_o), 64'd0);
    chk("rst_op_zero", 64'(csr_op_o), 64'd0);
    chk("rst_addr_zero", 64'(csr_addr_o), 64'd0);
    chk("rst_wdata_zero", csr_wdata_o, 64'd0);
    chk("rst_ready_zero", 64'(issue_ready_o), 64'd0);
    chk("rst_rdata_zero", rsp_rdata_o, 64'd0);
    chk("rst_hold_zero", 64'(hold_cycles_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_rsp", 64'(rsp_valid_o), 64'd0);
    end

    // 7: hold counter saturates
    csr_rdata_i = 64'h1;
    do_issue(2'b00, 1'b0, 12'hC00, 64'h0, 3'd0);
    for (int i = 0; i < 19; i++) tick();
    do_commit(3'd0, 1'b1);
    chk_access(2'b00, 12'hC00, 64'h0);
    tick();
    chk_resp(3'd0, 64'h1, 1'b0, 64'h0, 4'd15);
    finish_resp();

    tick();
    // Strobes for entries 1, 2, 3, 5, 7; the flushed and reset entries never complete.
    chk("total_req", 64'(n_req), 64'd5);
    chk("total_handshakes", 64'(n_hs), 64'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
